// File: rtl/sec_timer.sv
// BCD minutes:seconds stopwatch / countdown timer.
// Advances one second per tick pulse, counting up to MAX_MIN:59 or down to 00:00.
// Every output is registered, so any effect shows on the cycle after its inputs are sampled.
module sec_timer #(
    parameter int unsigned MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       count_down,
    input  logic       load,
    input  logic [7:0] preset_min,
    input  logic [7:0] preset_sec,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StDone  = 2'b11
    } state_e;

    localparam logic [3:0] MaxMinTens  = 4'(MAX_MIN / 10);
    localparam logic [3:0] MaxMinUnits = 4'(MAX_MIN % 10);
    localparam logic [7:0] MaxMinBcd   = {MaxMinTens, MaxMinUnits};

    state_e     state_q, state_d;
    logic       mode_q, mode_d;          // 1 = counting down
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic       done_q, done_d;
    logic       running_q, running_d;

    logic [7:0] min_inc, sec_inc;
    logic [7:0] min_dec, sec_dec;
    logic       at_ceiling, at_zero;
    logic       inc_at_ceiling, dec_at_zero;
    logic       preset_ok;

    // BCD increment chain: sec units -> sec tens -> min units -> min tens
    always_comb begin
        sec_inc = sec_q;
        min_inc = min_q;
        if (sec_q[3:0] == 4'd9) begin
            sec_inc[3:0] = 4'd0;
            if (sec_q[7:4] == 4'd5) begin
                sec_inc[7:4] = 4'd0;
                if (min_q[3:0] == 4'd9) begin
                    min_inc[3:0] = 4'd0;
                    min_inc[7:4] = min_q[7:4] + 4'd1;
                end else begin
                    min_inc[3:0] = min_q[3:0] + 4'd1;
                end
            end else begin
                sec_inc[7:4] = sec_q[7:4] + 4'd1;
            end
        end else begin
            sec_inc[3:0] = sec_q[3:0] + 4'd1;
        end
    end

    // BCD decrement chain, mirror of the increment with borrows
    always_comb begin
        sec_dec = sec_q;
        min_dec = min_q;
        if (sec_q[3:0] == 4'd0) begin
            sec_dec[3:0] = 4'd9;
            if (sec_q[7:4] == 4'd0) begin
                sec_dec[7:4] = 4'd5;
                if (min_q[3:0] == 4'd0) begin
                    min_dec[3:0] = 4'd9;
                    min_dec[7:4] = min_q[7:4] - 4'd1;
                end else begin
                    min_dec[3:0] = min_q[3:0] - 4'd1;
                end
            end else begin
                sec_dec[7:4] = sec_q[7:4] - 4'd1;
            end
        end else begin
            sec_dec[3:0] = sec_q[3:0] - 4'd1;
        end
    end

    // End-value detection and preset validation
    always_comb begin
        at_ceiling     = (min_q == MaxMinBcd) && (sec_q == 8'h59);
        at_zero        = (min_q == 8'h00) && (sec_q == 8'h00);
        inc_at_ceiling = (min_inc == MaxMinBcd) && (sec_inc == 8'h59);
        dec_at_zero    = (min_dec == 8'h00) && (sec_dec == 8'h00);
        // With all digits legal, BCD byte order equals numeric order
        preset_ok      = (preset_min[7:4] <= 4'd9) && (preset_min[3:0] <= 4'd9) &&
                         (preset_sec[7:4] <= 4'd5) && (preset_sec[3:0] <= 4'd9) &&
                         (preset_min <= MaxMinBcd);
    end

    // Next-state logic; priority clear > load > stop > start > tick
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        min_d   = min_q;
        sec_d   = sec_q;
        done_d  = 1'b0;

        if (clear) begin
            state_d = StIdle;
            mode_d  = 1'b0;
            min_d   = 8'h00;
            sec_d   = 8'h00;
        end else if (load && (state_q == StIdle || state_q == StDone)) begin
            // A rejected load still consumes the cycle
            if (preset_ok) begin
                state_d = StIdle;
                min_d   = preset_min;
                sec_d   = preset_sec;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mode_d = count_down;
                        if (count_down && at_zero) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StRun;
                        end
                    end
                end
                StRun: begin
                    if (stop) begin
                        state_d = StPause;
                    end else if (tick) begin
                        if (!mode_q) begin
                            if (at_ceiling) begin
                                state_d = StDone;
                                done_d  = 1'b1;
                            end else begin
                                min_d = min_inc;
                                sec_d = sec_inc;
                                if (inc_at_ceiling) begin
                                    state_d = StDone;
                                    done_d  = 1'b1;
                                end
                            end
                        end else begin
                            if (at_zero) begin
                                state_d = StDone;
                                done_d  = 1'b1;
                            end else begin
                                min_d = min_dec;
                                sec_d = sec_dec;
                                if (dec_at_zero) begin
                                    state_d = StDone;
                                    done_d  = 1'b1;
                                end
                            end
                        end
                    end
                end
                StPause: begin
                    if (start) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
                end
                default: begin
                end
            endcase
        end

        running_d = (state_d == StRun);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            mode_q    <= 1'b0;
            min_q     <= 8'h00;
            sec_q     <= 8'h00;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            done_q    <= done_d;
            running_q <= running_d;
        end
    end

    assign min_bcd = min_q;
    assign sec_bcd = sec_q;
    assign running = running_q;
    assign done    = done_q;
    assign state   = state_q;

endmodule

// File: doc/sec_timer.md
Name: sec_timer

Overview:
- BCD minutes:seconds stopwatch / countdown timer for the calculator's timer function.
- Sits directly downstream of the 1-per-second tick generator: consumes its one-cycle tick pulse and advances the time by one second per tick.
- Feeds BCD digits and status to the display/control logic.
- Counts up to a ceiling, or down from a loaded preset to 00:00, with start/stop/clear control.

Parameters:
- MAX_MIN, 59, highest minutes value reachable in up mode; legal range 0..99. Ceiling is MAX_MIN:59.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle pulse, one per second, from the tick generator
- start  in  1  one-cycle pulse; start from IDLE, resume from PAUSE
- stop  in  1  one-cycle pulse; pause while running
- clear  in  1  synchronous clear to 00:00 / IDLE
- count_down  in  1  mode select (1 = down); sampled only on start from IDLE
- load  in  1  one-cycle pulse; load preset_min / preset_sec
- preset_min  in  8  BCD minutes; [7:4] tens, [3:0] units
- preset_sec  in  8  BCD seconds; [7:4] tens, [3:0] units
- min_bcd  out  8  current minutes, BCD
- sec_bcd  out  8  current seconds, BCD
- running  out  1  high while in RUN
- done  out  1  one-cycle pulse on reaching end value
- state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11

Behaviour:
- Reset (asynchronous, active-high) clears all outputs to 0, state to IDLE, and the internal mode register to up.
- All outputs are registered. Effects of control inputs and tick appear on the cycle after they are sampled.
- Per-cycle input priority: clear > load > stop > start > tick.
- clear: any state -> IDLE, time 00:00, done=0, mode=up.
- load:
  - Accepted only in IDLE or DONE; goes to IDLE with the preset value.
  - Ignored in RUN or PAUSE.
  - Rejected (no change) if any digit > 9, sec tens > 5, or preset minutes > MAX_MIN in BCD value.
- IDLE + start:
  - Latch count_down into the mode register; go to RUN.
  - A tick in the same cycle is ignored; the first count happens on the next tick.
  - Down mode with time already 00:00: go to DONE, done=1 for one cycle, no RUN cycle.
- RUN + stop: go to PAUSE. A simultaneous tick is not counted.
- PAUSE + start: go to RUN; a same-cycle tick is ignored. tick is ignored in PAUSE.
- start in RUN or DONE is ignored. stop outside RUN is ignored.
- Up-mode count, on each tick in RUN:
  - sec units wrap 9->0 with carry into sec tens; sec tens wrap 5->0 with carry into minutes (units 9->0, then tens).
  - The tick that produces MAX_MIN:59 updates the time, moves to DONE, and pulses done.
  - Time holds at MAX_MIN:59.
- Down-mode count, on each tick in RUN:
  - Mirror borrow chain: sec 00 -> 59 with a borrow from minutes.
  - The tick that produces 00:00 moves to DONE and pulses done.
  - Never wraps below 00:00.
- DONE: time frozen; running=0; leave only via clear or load.
- done is high for exactly one cycle, the same cycle the final value first appears on min_bcd/sec_bcd.
- running = (state == RUN), registered with state.
- Back-to-back ticks on consecutive cycles must each count (no internal tick-rate assumption).

Test Plan:
- Reset mid-RUN at 00:07 -> same/next observation: state=00, min_bcd=00, sec_bcd=00, running=0, done=0.
- Up mode: start, 60 ticks -> min_bcd=0x01, sec_bcd=0x00. Continue to 59:59 (MAX_MIN=59) -> done pulses one cycle, state=11. Further ticks leave 59:59.
- Load 0x01/0x00, count_down=1, start; 1 tick -> 00:59. 59 more ticks -> 00:00, done one cycle, state=11.
- In RUN at 00:10: stop and tick in the same cycle -> PAUSE, 00:10. 3 ticks -> unchanged. start with a same-cycle tick -> RUN, 00:10. Next tick -> 00:11.
- Load invalid preset_sec=0x60 in IDLE -> time and state unchanged. Load 0x00/0x00, count_down=1, start -> DONE next cycle with done=1.
- clear and load asserted together in DONE -> IDLE at 00:00, preset discarded. load while in RUN -> ignored, count continues.
